// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, states, datapath select codes.
// No logic beyond the legality helper.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MADDR = 4'd2,  S_MREAD = 4'd3,
        S_MWB    = 4'd4,  S_MWRITE = 4'd5,  S_EXEC  = 4'd6,  S_RWB   = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC = 4'd10, S_IWB   = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13, S_TRAP  = 4'd14, S_RST   = 4'd15
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_AND = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11;
    localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
    localparam logic [1:0] M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
    localparam logic [1:0] SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic       instr_retire;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-register fields, memory ready and datapath control bundle.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] op_code;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
    logic       illegal;
    logic       instr_retire;
    logic [3:0] state;

    modport master (
        input  op_code, funct, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite,
        output RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, illegal, instr_retire, state
    );

    modport slave (
        output op_code, funct, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite,
        input  RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, illegal, instr_retire, state
    );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Output decoder: current state (+ opcode, effective mem ready) -> datapath controls.
// Purely combinational, zero latency; write enables in wait states depend on ready.
module multicycle_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  state_t     state,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b    = SRCB_IMM_SH2;
                // An illegal opcode without trapping completes here as a NOP.
                ctrl.instr_retire = !TRAP_ON_ILLEGAL && !is_legal(op_code);
            end
            S_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MWB: begin
                ctrl.mem_to_reg   = M2R_MDR;
                ctrl.reg_write    = 1'b1;
                ctrl.instr_retire = 1'b1;
            end
            S_MWRITE: begin
                ctrl.mem_write    = 1'b1;
                ctrl.i_or_d       = 1'b1;
                ctrl.instr_retire = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_dst      = DST_RD;
                ctrl.reg_write    = 1'b1;
                ctrl.instr_retire = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
                ctrl.instr_retire  = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write     = 1'b1;
                ctrl.pc_source    = PC_JUMP;
                ctrl.instr_retire = 1'b1;
            end
            S_IEXEC, S_IWB: begin
                // ALU controls stay up through write-back so ALUOut's source is unchanged.
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_IMM;
                ctrl.alu_op       = (op_code == OP_ANDI) ? ALU_AND : ALU_ADD;
                ctrl.reg_write    = (state == S_IWB);
                ctrl.instr_retire = (state == S_IWB);
            end
            S_JAL: begin
                ctrl.pc_write     = 1'b1;
                ctrl.pc_source    = PC_JUMP;
                ctrl.reg_dst      = DST_RA;
                ctrl.mem_to_reg   = M2R_PC;
                ctrl.reg_write    = 1'b1;
                ctrl.instr_retire = 1'b1;
            end
            S_JR: begin
                ctrl.pc_write     = 1'b1;
                ctrl.pc_source    = PC_RS;
                ctrl.instr_retire = 1'b1;
            end
            S_TRAP:  ctrl.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, output decoder.
// 3-5 cycles per instruction; FETCH/MREAD/MWRITE stall while mem_ready is low.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multicycle_control_if.master  bus
);

    state_t state_q;
    state_t state_d;
    logic   ready;
    ctrl_t  ctrl;

    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    multicycle_ctrl_outdec #(
        .TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)
    ) u_outdec (
        .state     (state_q),
        .op_code   (bus.op_code),
        .mem_ready (ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op_code)
                    OP_LW, OP_SW:     state_d = S_MADDR;
                    OP_RTYPE:         state_d = (bus.funct == FUNCT_JR) ? S_JR : S_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI: state_d = S_IEXEC;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MADDR:  state_d = (bus.op_code == OP_SW) ? S_MWRITE : S_MREAD;
            S_MREAD:  state_d = ready ? S_MWB : S_MREAD;
            S_MWRITE: state_d = ready ? S_FETCH : S_MWRITE;
            S_EXEC:   state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            S_MWB, S_RWB, S_BRANCH, S_JUMP, S_IWB, S_JAL, S_JR: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_RST;
        else          state_q <= state_d;
    end

    // Outputs decode straight from the state register, so reset clears them asynchronously.
    assign bus.PCWrite      = ctrl.pc_write;
    assign bus.PCWriteCond  = ctrl.pc_write_cond;
    assign bus.IorD         = ctrl.i_or_d;
    assign bus.MemRead      = ctrl.mem_read;
    assign bus.MemWrite     = ctrl.mem_write;
    assign bus.IRWrite      = ctrl.ir_write;
    assign bus.ALUSrcA      = ctrl.alu_src_a;
    assign bus.RegWrite     = ctrl.reg_write;
    assign bus.RegDst       = ctrl.reg_dst;
    assign bus.MemtoReg     = ctrl.mem_to_reg;
    assign bus.ALUSrcB      = ctrl.alu_src_b;
    assign bus.ALUOp        = ctrl.alu_op;
    assign bus.PCSource     = ctrl.pc_source;
    assign bus.illegal      = ctrl.illegal;
    assign bus.instr_retire = ctrl.instr_retire;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus a random instruction stream
// with random memory stalls, checked against per-instruction traces and CPI rules.
module tb_multicycle_control;

    localparam logic [5:0] R_OP = 6'b000000, J_OP = 6'b000010, JAL_OP = 6'b000011, BEQ_OP = 6'b000100;
    localparam logic [5:0] ADDI_OP = 6'b001000, ANDI_OP = 6'b001100, LW_OP = 6'b100011, SW_OP = 6'b101011;
    localparam logic [5:0] JR_FN = 6'b001000, ADD_FN = 6'b100000, BAD_OP = 6'b111111;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    int   tr_st[$];
    bit   tr_rdy[$];

    multicycle_control_if bus ();
    multicycle_control_if bus2 ();

    multicycle_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    multicycle_control #(
        .MEM_HANDSHAKE   (1'b0),
        .TRAP_ON_ILLEGAL (1'b0)
    ) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] obs, obs2;
    assign obs  = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                   bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcB, bus.ALUOp,
                   bus.PCSource, bus.illegal, bus.instr_retire};
    assign obs2 = {bus2.PCWrite, bus2.PCWriteCond, bus2.IorD, bus2.MemRead, bus2.MemWrite, bus2.IRWrite,
                   bus2.ALUSrcA, bus2.RegWrite, bus2.RegDst, bus2.MemtoReg, bus2.ALUSrcB, bus2.ALUOp,
                   bus2.PCSource, bus2.illegal, bus2.instr_retire};

    // Control word each step of an instruction must present, written from the step descriptions.
    function automatic logic [19:0] exp_vec(input int st, input logic [5:0] op, input bit rdy);
        logic pcw, pcwc, iord, mr, mw, irw, asa, rw, ill, ret;
        logic [1:0] rd, m2r, asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, asa, rw, ill, ret} = '0;
        {rd, m2r, asb, aop, pcs} = '0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin m2r = 2'b01; rw = 1; ret = 1; end
            5:  begin mw = 1; iord = 1; ret = rdy; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 2'b01; rw = 1; ret = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; ret = 1; end
            9:  begin pcw = 1; pcs = 2'b10; ret = 1; end
            10, 11: begin
                asa = 1; asb = 2'b10; aop = (op == ANDI_OP) ? 2'b11 : 2'b00;
                rw = (st == 11); ret = (st == 11);
            end
            12: begin pcw = 1; pcs = 2'b10; rd = 2'b10; m2r = 2'b10; rw = 1; ret = 1; end
            13: begin pcw = 1; pcs = 2'b11; ret = 1; end
            14: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, asa, rw, rd, m2r, asb, aop, pcs, ill, ret};
    endfunction

    // Cycles per instruction with no stalls.
    function automatic int cpi(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            BEQ_OP, J_OP, JAL_OP: return 3;
            R_OP:                 return (fn == JR_FN) ? 3 : 4;
            LW_OP:                return 5;
            default:              return 4;
        endcase
    endfunction

    task automatic push(input int s, input bit r);
        tr_st.push_back(s);
        tr_rdy.push_back(r);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one instruction on dut from FETCH; caller is at a falling edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fst, input int mst,
                             input string nm);
        int ret_cnt, ret_at, eff;
        tr_st.delete();
        tr_rdy.delete();
        for (int i = 0; i < fst; i++) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'b1);
        case (op)
            LW_OP: begin
                push(2, 1'b1);
                for (int i = 0; i < mst; i++) push(3, 1'b0);
                push(3, 1'b1);
                push(4, 1'b1);
            end
            SW_OP: begin
                push(2, 1'b1);
                for (int i = 0; i < mst; i++) push(5, 1'b0);
                push(5, 1'b1);
            end
            R_OP:             if (fn == JR_FN) push(13, 1'b1); else begin push(6, 1'b1); push(7, 1'b1); end
            BEQ_OP:           push(8, 1'b1);
            ADDI_OP, ANDI_OP: begin push(10, 1'b1); push(11, 1'b1); end
            J_OP:             push(9, 1'b1);
            JAL_OP:           push(12, 1'b1);
            default:          ;
        endcase
        bus.op_code = op;
        bus.funct   = fn;
        ret_cnt = 0;
        ret_at  = -1;
        for (int k = 0; k < tr_st.size(); k++) begin
            bus.mem_ready = tr_rdy[k];
            #1;
            checks++;
            if (bus.state !== 4'(tr_st[k])) begin
                errors++;
                $display("FAIL %s state cycle %0d: got %0d want %0d", nm, k, bus.state, tr_st[k]);
            end
            checks++;
            if (obs !== exp_vec(tr_st[k], op, tr_rdy[k])) begin
                errors++;
                $display("FAIL %s controls cycle %0d: got %b want %b", nm, k, obs,
                         exp_vec(tr_st[k], op, tr_rdy[k]));
            end
            if (bus.instr_retire === 1'b1) begin ret_cnt++; ret_at = k; end
            @(posedge clk);
            @(negedge clk);
        end
        eff = cpi(op, fn) + fst + ((op == LW_OP || op == SW_OP) ? mst : 0);
        checks++;
        if (ret_cnt != 1) begin
            errors++;
            $display("FAIL %s retire count: got %0d want 1", nm, ret_cnt);
        end
        checks++;
        if (ret_at + 1 != eff) begin
            errors++;
            $display("FAIL %s cycles to retire: got %0d want %0d", nm, ret_at + 1, eff);
        end
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL %s back to fetch: got state %0d want 0", nm, bus.state);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.op_code = R_OP;  bus.funct = ADD_FN;  bus.mem_ready = 1'b1;
        bus2.op_code = R_OP; bus2.funct = ADD_FN; bus2.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd15 || obs !== 20'd0) begin
            errors++;
            $display("FAIL reset state/outputs: got %0d/%b want 15/0", bus.state, obs);
        end
        checks++;
        if (bus2.state !== 4'd15 || obs2 !== 20'd0) begin
            errors++;
            $display("FAIL reset state/outputs dut2: got %0d/%b want 15/0", bus2.state, obs2);
        end
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd0 || bus2.state !== 4'd0) begin
            errors++;
            $display("FAIL first fetch: got %0d,%0d want 0,0", bus.state, bus2.state);
        end
    endtask

    // Non-trapping, handshake-free instance: illegal opcode retires as a NOP.
    task automatic test_illegal_nop();
        int want_st [3] = '{0, 1, 0};
        int rets = 0;
        bus.mem_ready = 1'b0;
        bus2.op_code  = BAD_OP;
        bus2.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus2.state !== 4'(want_st[k])) begin
                errors++;
                $display("FAIL nop state cycle %0d: got %0d want %0d", k, bus2.state, want_st[k]);
            end
            if (k == 0) begin
                checks++;
                if (bus2.IRWrite !== 1'b1 || bus2.PCWrite !== 1'b1) begin
                    errors++;
                    $display("FAIL nop fetch ignores mem_ready: got IRWrite=%b PCWrite=%b want 1,1",
                             bus2.IRWrite, bus2.PCWrite);
                end
            end
            if (k < 2 && bus2.instr_retire === 1'b1) rets++;
            if (k == 1) begin
                checks++;
                if (bus2.illegal !== 1'b0 || bus2.RegWrite !== 1'b0) begin
                    errors++;
                    $display("FAIL nop decode: got illegal=%b RegWrite=%b want 0,0", bus2.illegal, bus2.RegWrite);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus2.op_code = R_OP;
        checks++;
        if (rets != 1) begin
            errors++;
            $display("FAIL nop retire count: got %0d want 1", rets);
        end
    endtask

    task automatic test_add();       run_instr(R_OP, ADD_FN, 0, 0, "add");     endtask
    task automatic test_lw_stall();  run_instr(LW_OP, 6'd0, 0, 2, "lw_stall"); endtask
    task automatic test_jal();       run_instr(JAL_OP, 6'd0, 0, 0, "jal");     endtask
    task automatic test_jr();        run_instr(R_OP, JR_FN, 0, 0, "jr");       endtask

    task automatic test_random();
        int sel, fst, mst;
        logic [5:0] op, fn;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 8);
            fn  = 6'($urandom_range(0, 63));
            fst = $urandom_range(0, 2);
            mst = $urandom_range(0, 3);
            case (sel)
                0: begin op = R_OP; if (fn == JR_FN) fn = ADD_FN; end
                1: begin op = R_OP; fn = JR_FN; end
                2: op = J_OP;
                3: op = JAL_OP;
                4: op = BEQ_OP;
                5: op = ADDI_OP;
                6: op = ANDI_OP;
                7: op = LW_OP;
                default: op = SW_OP;
            endcase
            run_instr(op, fn, fst, mst, "random");
        end
    endtask

    task automatic test_trap();
        bus.op_code   = BAD_OP;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd1 || bus.instr_retire !== 1'b0) begin
            errors++;
            $display("FAIL trap decode: got state %0d retire %b want 1,0", bus.state, bus.instr_retire);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (bus.state !== 4'd14 || obs !== 20'b10) begin
                errors++;
                $display("FAIL trap hold cycle %0d: got state %0d controls %b want 14 and only illegal",
                         k, bus.state, obs);
            end
        end
        do_reset();
    endtask

    task automatic test_mwrite_reset();
        bus.op_code   = SW_OP;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd5 || bus.MemWrite !== 1'b1 || bus.instr_retire !== 1'b0) begin
            errors++;
            $display("FAIL mwrite wait: got state %0d MemWrite %b retire %b want 5,1,0",
                     bus.state, bus.MemWrite, bus.instr_retire);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd15 || obs !== 20'd0) begin
            errors++;
            $display("FAIL async reset: got state %0d controls %b want 15 and 0", bus.state, obs);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd15 || obs !== 20'd0) begin
            errors++;
            $display("FAIL reset held: got state %0d controls %b want 15 and 0", bus.state, obs);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL fetch after release: got %0d want 0", bus.state);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_illegal_nop();
        test_add();
        test_lw_stall();
        test_jal();
        test_jr();
        test_random();
        test_trap();
        test_mwrite_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
